// File: rtl/adder_selftest_driver.sv
// Self-test driver for the registered nibble adder: sweeps every operand pair,
// compares each returned sum with the expected value and reports the outcome.
module adder_selftest_driver #(
    parameter int NIBBLE_W = 4,
    parameter int LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [2*NIBBLE_W-1:0] ops_out,
    input  logic [NIBBLE_W:0]     sum_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2*NIBBLE_W:0]   err_count,
    output logic [2*NIBBLE_W-1:0] first_fail
);

    localparam int OPS_W = 2 * NIBBLE_W;
    localparam int SUM_W = NIBBLE_W + 1;
    localparam int ERR_W = OPS_W + 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DRAIN,
        FINISHED
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     drain_cnt;
    logic [LATENCY-1:0]   pipe_valid;
    logic [OPS_W-1:0]     pipe_ops [LATENCY];

    logic [OPS_W-1:0]     tail_ops;
    logic [SUM_W-1:0]     expected;
    logic                 mismatch;

    // The oldest pipeline entry is the pattern whose sum the adder presents now.
    always_comb begin
        tail_ops = pipe_ops[LATENCY-1];
        expected = SUM_W'(tail_ops[NIBBLE_W-1:0]) + SUM_W'(tail_ops[OPS_W-1:NIBBLE_W]);
        mismatch = pipe_valid[LATENCY-1] && (sum_in != expected)
                   && ((state == DRIVE) || (state == DRAIN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_ops[i]   <= '0;
            end
        end else begin
            pipe_valid[0] <= (state == DRIVE);
            pipe_ops[0]   <= ops_out;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_ops[i]   <= pipe_ops[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            ops_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            if (mismatch) begin
                err_count <= err_count + ERR_W'(1);
                if (err_count == '0)
                    first_fail <= tail_ops;
            end
            case (state)
                IDLE, FINISHED: begin
                    if (start) begin
                        state      <= DRIVE;
                        ops_out    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= '0;
                    end
                end
                DRIVE: begin
                    if (ops_out == '1) begin
                        state     <= DRAIN;
                        drain_cnt <= CNT_W'(LATENCY - 1);
                    end else begin
                        ops_out <= ops_out + OPS_W'(1);
                    end
                end
                DRAIN: begin
                    // The final compare lands on this same edge, so fold it into pass.
                    if (drain_cnt == '0) begin
                        state <= FINISHED;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_selftest_driver.sv
// Scoreboard bench for adder_selftest_driver: two instances (latency 1 and 3) loop back
// through a bench-side adder model with selectable depth and injectable faults.
module tb_adder_selftest_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] ops0, ops1;
    logic [4:0] sum0, sum1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [8:0] err0, err1;
    logic [7:0] ff0, ff1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int         err;
        logic [7:0] ff;
        int         busy_len;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Loopback adder model: configurable pipeline depth and fault injection per instance.
    logic [7:0] p0 [3];
    logic [7:0] p1 [3];
    int mdepth0 = 1, mdepth1 = 3;
    int fmode0 = 0, fmode1 = 0;
    int fpat0 = 0, fpat1 = 0;

    int         busy_cnt0 = 0, busy_cnt1 = 0;
    logic       prev_done0 = 1'b0, prev_done1 = 1'b0;

    always #5 clk = ~clk;

    adder_selftest_driver #(.NIBBLE_W(4), .LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .ops_out(ops0), .sum_in(sum0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
    );

    adder_selftest_driver #(.NIBBLE_W(4), .LATENCY(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ops_out(ops1), .sum_in(sum1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
    );

    function automatic logic [4:0] ideal(logic [7:0] o);
        return {1'b0, o[3:0]} + {1'b0, o[7:4]};
    endfunction

    function automatic logic [4:0] faulty(logic [7:0] o, int mode, int pat);
        logic [4:0] s;
        s = ideal(o);
        case (mode)
            1: s[4] = 1'b0;
            2: s[0] = 1'b0;
            3: if (o == 8'(pat)) s = s ^ 5'h04;
            default: ;
        endcase
        return s;
    endfunction

    always @(posedge clk) begin
        p0[0] <= ops0; p0[1] <= p0[0]; p0[2] <= p0[1];
        p1[0] <= ops1; p1[1] <= p1[0]; p1[2] <= p1[1];
    end

    assign sum0 = faulty(p0[mdepth0-1], fmode0, fpat0);
    assign sum1 = faulty(p1[mdepth1-1], fmode1, fpat1);

    // Reference: the checker compares pattern t against the sum of whatever pattern the
    // model adder is emitting LAT cycles later, which is pattern t+LAT-depth (0xFF once held).
    function automatic void compute_expected(int lat, int md, int mode, int pat,
                                             output int err, output logic [7:0] ff);
        int src;
        err = 0;
        ff  = 8'h00;
        for (int t = 0; t < 256; t++) begin
            src = t + lat - md;
            if (src > 255) src = 255;
            if (faulty(8'(src), mode, pat) != ideal(8'(t))) begin
                if (err == 0) ff = 8'(t);
                err++;
            end
        end
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic score(int d, logic p, logic [8:0] e, logic [7:0] f, int blen);
        exp_t x;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done dut%0d: got done with empty scoreboard, expected none", d);
        end else begin
            if (d == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            check_output($sformatf("dut%0d pass", d), 32'(p), 32'(x.err == 0));
            check_output($sformatf("dut%0d err_count", d), 32'(e), 32'(x.err));
            check_output($sformatf("dut%0d first_fail", d), 32'(f), 32'(x.ff));
            check_output($sformatf("dut%0d busy_cycles", d), 32'(blen), 32'(x.busy_len));
        end
    endtask

    // Monitor: measures busy duration and scores each completed run as done rises.
    always @(negedge clk) begin
        if (busy0) busy_cnt0++;
        else begin
            if (done0 && !prev_done0) score(0, pass0, err0, ff0, busy_cnt0);
            busy_cnt0 = 0;
        end
        if (busy1) busy_cnt1++;
        else begin
            if (done1 && !prev_done1) score(1, pass1, err1, ff1, busy_cnt1);
            busy_cnt1 = 0;
        end
        prev_done0 = done0;
        prev_done1 = done1;
    end

    task automatic set_start(int d, logic v);
        if (d == 0) start0 = v;
        else        start1 = v;
    endtask

    task automatic check_reset_values(int d);
        if (d == 0) begin
            check_output("dut0 rst ops_out", 32'(ops0), 0);
            check_output("dut0 rst busy", 32'(busy0), 0);
            check_output("dut0 rst done", 32'(done0), 0);
            check_output("dut0 rst pass", 32'(pass0), 0);
            check_output("dut0 rst err_count", 32'(err0), 0);
            check_output("dut0 rst first_fail", 32'(ff0), 0);
        end else begin
            check_output("dut1 rst ops_out", 32'(ops1), 0);
            check_output("dut1 rst busy", 32'(busy1), 0);
            check_output("dut1 rst done", 32'(done1), 0);
            check_output("dut1 rst pass", 32'(pass1), 0);
            check_output("dut1 rst err_count", 32'(err1), 0);
            check_output("dut1 rst first_fail", 32'(ff1), 0);
        end
    endtask

    // One full run: configure the model, push the expected outcome, pulse start and
    // wait (bounded) for done; optionally pulse start again mid-sweep.
    task automatic apply_stimulus(int d, int md, int mode, int pat, bit inject);
        exp_t x;
        int   lat;
        bit   finished;
        lat = (d == 0) ? 1 : 3;
        if (d == 0) begin mdepth0 = md; fmode0 = mode; fpat0 = pat; end
        else        begin mdepth1 = md; fmode1 = mode; fpat1 = pat; end
        compute_expected(lat, md, mode, pat, x.err, x.ff);
        x.busy_len = 256 + lat;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        finished = 1'b0;
        for (int c = 0; c < 700 && !finished; c++) begin
            @(negedge clk);
            set_start(d, inject && (c == 100));
            if ((d == 0 && done0) || (d == 1 && done1)) finished = 1'b1;
        end
        set_start(d, 1'b0);
        if (!finished) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL run_timeout dut%0d: got no done, expected done within 700 cycles", d);
        end
        @(negedge clk);
    endtask

    // Abort a run on dut0 at pattern 0x40 and check the very next edge restores reset values.
    task automatic reset_mid_run();
        bit hit;
        mdepth0 = 1; fmode0 = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (ops0 == 8'h40) hit = 1'b1;
            else @(negedge clk);
        end
        check_output("dut0 reached_0x40", 32'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values(0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int d, md, mode, pat;
        bit inj;
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values(0);
        check_reset_values(1);
        rst = 1'b0;
        @(negedge clk);

        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 0);
        apply_stimulus(0, 1, 2, 0, 0);
        apply_stimulus(1, 3, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0);
        apply_stimulus(1, 3, 0, 0, 0);
        reset_mid_run();
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 1);
        apply_stimulus(1, 3, 3, 8'hFF, 1);

        for (int i = 0; i < 8; i++) begin
            d    = $urandom_range(0, 1);
            md   = (d == 1) ? $urandom_range(1, 3) : 1;
            mode = $urandom_range(0, 3);
            pat  = $urandom_range(0, 255);
            inj  = 1'($urandom_range(0, 1));
            apply_stimulus(d, md, mode, pat, inj);
        end

        repeat (4) @(negedge clk);
        check_output("dut0 scoreboard_drained", 32'(q0.size()), 0);
        check_output("dut1 scoreboard_drained", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
